// File: rtl/detect_word_pkg.sv
// detect_word_pkg: shared encodings and helpers for the detect-word arbiter.
package detect_word_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_state_t;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, REPORT = 2'b10} ctrl_state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/zero_run_detector.sv
// zero_run_detector: Mealy detector pulsing y on a zero that follows one or more ones.
module zero_run_detector
  import detect_word_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       x,
  output logic       y,
  output det_state_t state
);
  det_state_t nxt;
  always_comb begin
    nxt = !x ? S0 : state == S0 ? S1 : state == S1 ? S3 : S2;
    y = !x && state != S0;
  end
  always_ff @(posedge clock) begin
    state <= (!reset || clr) ? S0 : en ? nxt : state;
  end
endmodule

// File: rtl/detect_word_arbiter.sv
// detect_word_arbiter: two requesters share one serial zero-after-ones detector; reports pulse count per word.
// Define DWA_FIXED_PRIO_EN for fixed requester-0 priority instead of round-robin.
module detect_word_arbiter
  import detect_word_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  output logic [1:0]       det_state
);
  ctrl_state_t      state, nxt_state;
  det_state_t       det;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] bit_cnt, count;
  logic             owner, gnt1, idle, accept, last_bit, y;
`ifndef DWA_FIXED_PRIO_EN
  logic             ptr;
  always_ff @(posedge clock) begin
    if (!reset) ptr <= 1'b0;
    else if (state == REPORT) ptr <= ~res_id;
  end
`endif
  always_comb begin
    idle = state == IDLE;
`ifdef DWA_FIXED_PRIO_EN
    gnt1 = req1_valid && !req0_valid;
`else
    gnt1 = req1_valid && (!req0_valid || ptr);
`endif
    req1_ready = reset && idle && gnt1;
    req0_ready = reset && idle && req0_valid && !gnt1;
    accept = req0_ready || req1_ready;
    last_bit = bit_cnt == '0;
    nxt_state = idle ? (accept ? SHIFT : IDLE) : state == SHIFT ? (last_bit ? REPORT : SHIFT) : IDLE;
    busy = !idle;
    res_valid = state == REPORT;
    det_state = det;
  end
  // Result registers load on the last shift so they appear with the REPORT strobe and hold afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      word <= '0;
      bit_cnt <= '0;
      count <= '0;
      owner <= 1'b0;
      res_id <= 1'b0;
      res_count <= '0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        word <= req1_ready ? req1_data : req0_data;
        bit_cnt <= CNT_W'(WIDTH - 1);
        count <= '0;
        owner <= req1_ready;
      end else if (state == SHIFT) begin
        word <= {word[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
        count <= count + CNT_W'(y);
        if (last_bit) begin
          res_id <= owner;
          res_count <= count + CNT_W'(y);
        end
      end
    end
  end
  zero_run_detector u_det (
    .clock(clock),
    .reset(reset),
    .clr  (accept),
    .en   (state == SHIFT),
    .x    (word[WIDTH-1]),
    .y    (y),
    .state(det)
  );
endmodule

// File: tb/tb_detect_word_arbiter.sv
// tb_detect_word_arbiter: directed and random stimulus against a transaction-level model of the arbiter.
module tb_detect_word_arbiter;
  import detect_word_pkg::*;
  localparam int W  = 8;
  localparam int CW = clog2(W + 1);
`ifdef DWA_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic          clock = 1'b0, reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0]  req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, busy, res_valid, res_id;
  logic [CW-1:0] res_count;
  logic [1:0]    det_state;
  int n_cmp = 0, n_err = 0;
  int phase = 0, mid = 0, mcnt = 0, last_id = 0, last_cnt = 0, ptr = 0;
  logic [1:0]    det_exp = 2'b00;
  logic [W-1:0]  mword = '0;

  always #5 clock = ~clock;

  detect_word_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .det_state(det_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulses are the "1 then 0" adjacencies in the MSB-first bit stream.
  function automatic int pulses(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W - 1; i++) if (w[i+1] && !w[i]) n++;
    return n;
  endfunction

  // Detector state after a word depends only on the trailing run of ones.
  function automatic logic [1:0] tail_state(input logic [W-1:0] w);
    int t = 0;
    while (t < W && w[t]) t++;
    return t == 0 ? 2'b00 : t == 1 ? 2'b01 : t == 2 ? 2'b11 : 2'b10;
  endfunction

  task automatic cyc(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1, input logic rs);
    int w;
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1; reset = rs;
    @(negedge clock);
    w = -1;
    if (rs && phase == 0) begin
      if (v0 && v1) w = FIXED ? 0 : ptr;
      else if (v0) w = 0;
      else if (v1) w = 1;
    end
    check("req0_ready", req0_ready, w == 0);
    check("req1_ready", req1_ready, w == 1);
    check("busy", busy, phase != 0);
    check("res_valid", res_valid, phase == W + 1);
    check("res_id", res_id, last_id);
    check("res_count", res_count, last_cnt);
    if (phase == 0 || phase == W + 1) check("det_state", det_state, det_exp);
    if (!rs) begin
      phase = 0; last_id = 0; last_cnt = 0; ptr = 0; det_exp = 2'b00;
    end else if (w >= 0) begin
      mid = w; mword = w ? d1 : d0; mcnt = pulses(mword); phase = 1;
    end else if (phase == W + 1) begin
      phase = 0; ptr = 1 - mid;
    end else if (phase == W) begin
      phase = W + 1; last_id = mid; last_cnt = mcnt; det_exp = tail_state(mword);
    end else if (phase > 0) phase++;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (phase != 0 && k < 40) begin
      cyc(1'b0, W'($urandom), 1'b0, W'($urandom), 1'b1);
      k++;
    end
    check("drain_done", phase, 0);
  endtask

  task automatic send(input int id, input logic [W-1:0] wd);
    int k = 0;
    while (phase == 0 && k < 20) begin
      cyc(id == 0, wd, id == 1, wd, 1'b1);
      k++;
    end
    check("send_accepted", phase != 0, 1);
    drain();
  endtask

  initial begin
    @(posedge clock);
    #1;
    cyc(1'b1, 8'hAA, 1'b1, 8'h55, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    send(0, 8'hAA);
    send(1, 8'h00);
    send(1, 8'hFF);
    send(1, 8'hF0);
    send(1, 8'h55);
    repeat (44) cyc(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
    drain();
    cyc(1'b1, 8'hAA, 1'b0, 8'h00, 1'b1);
    repeat (3) cyc(1'b0, W'($urandom), 1'b0, W'($urandom), 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    send(1, 8'hF0);
    repeat (3000)
      cyc($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 2) != 0, W'($urandom),
          $urandom_range(0, 299) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/detect_word_arbiter.md
Name: detect_word_arbiter

Overview:
Shares one serial zero-after-ones Mealy detector between two requesters. Accepts a WIDTH-bit word from the granted requester and shifts it MSB-first into the detector, one bit per clock. Counts the detector's output pulses and reports the count, tagged with the requester id. Sits between two word-producing front ends and the single shared detector resource.

Parameters:
WIDTH, 8, word length in bits (≥2); CNT_W = clog2(WIDTH+1) is a derived localparam.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle when valid
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle when valid
busy  output  1  word in flight (state != IDLE)
res_valid  output  1  one-cycle result strobe
res_id  output  1  requester that owns the result
res_count  output  CNT_W  number of detector pulses for the word
det_state  output  2  current detector state (debug)

Behaviour:
- Reset: clock and reset are synchronous, active-low; reset is sampled on the rising clock edge.
- Reset values: state=IDLE, ptr=0, busy=0, res_valid=0, res_id=0, res_count=0, det_state=S0, both ready=0.
- Controller states: IDLE -> SHIFT -> REPORT -> IDLE.
- IDLE:
  - Grant is combinational. If only one valid, that requester wins. If both valid, the requester selected by ptr wins.
  - Only the winner's ready=1, and only while in IDLE.
  - Transfer occurs on valid&&ready at cycle T. The word is captured, bit counter=WIDTH-1, detector forced to S0, running count cleared, and state moves to SHIFT.
- SHIFT:
  - One bit per cycle, MSB first, during cycles T+1..T+WIDTH.
  - If detector y=1 for the current bit, count increments.
  - After the LSB, state moves to REPORT.
  - Requester valid/data changes after the transfer are ignored.
- REPORT (cycle T+WIDTH+1):
  - res_valid=1 for exactly one cycle, with res_id and res_count.
  - ptr := ~res_id.
  - State returns to IDLE.
  - res_id and res_count hold their values until the next REPORT.
- Timing: latency from accept to res_valid is WIDTH+1 cycles. The earliest next accept is T+WIDTH+2.
- Detector (Mealy, fully specified, no latched output):
  - x=1: S0->S1, S1->S3, S3->S2, S2->S2.
  - x=0: any state -> S0.
  - y=1 iff x=0 and state!=S0; otherwise y=0.
  - The detector only advances in SHIFT and holds its state in other states.
- Count never overflows: max pulses = floor(WIDTH/2) < 2^CNT_W.
- Reset asserted mid-word aborts the word: no res_valid, all reset values restored, the word is lost.
- No valid in IDLE: stay in IDLE, no readies asserted.

Optional Feature:
- Macro: DWA_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; ptr is not implemented.
- Undefined: round-robin via ptr as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package detect_word_pkg: detector state encodings S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11; controller state encodings IDLE/SHIFT/REPORT; a clog2 function.
- Sub-module zero_run_detector.
  - Inputs: clock, reset, clr, en, x.
  - Outputs: y (combinational Mealy output), state.
  - Instantiated once.

Test Plan:
- Reset, then req0 word 8'hAA -> req0_ready at T; res_valid at T+9 with res_id=0, res_count=4.
- req1 words 8'h00, then 8'hFF, then 8'hF0 -> res_count=0, 0, 1 respectively, all with res_id=1.
- req1 word 8'h55 -> res_count=3 (the leading zero, seen in S0, is not counted).
- Both valid continuously, req0=8'hAA, req1=8'h55 -> grants alternate 0,1,0,1, results 4,3,4,3, each res_valid spaced 10 cycles apart. With DWA_FIXED_PRIO_EN the grants are 0,0,0,0 instead.
- Reset driven low at T+4 during a word -> next cycle state=IDLE, busy=0, no res_valid, det_state=S0. A fresh word after release reports its correct count.
- Valid dropped and data changed during SHIFT -> res_count matches the captured word; no ready asserted while busy=1.
